stream_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one valid/ready stream sink between NUM_REQ requesters. The sink is typically a short FIFO.
- Grants are packet-based. Once the first beat of a packet is accepted, the grant stays with that requester until its last beat is accepted.
- Zero-latency combinational forwarding path. Grant pointer and lock state are registered.
- Sits in front of shared buffers in AXI-stream style merge points, e.g. multiple masters feeding one response FIFO.

---
 rtl/stream_arb_pkg.sv | 38 +++
 rtl/stream_rr_arbiter_pick.sv | 22 ++
 rtl/stream_rr_arbiter.sv | 81 ++++++++
 tb/tb_stream_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared state type and round-robin helpers for stream arbiters
package stream_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  localparam int MAX_REQ = 32;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester after ptr in circular order; returns ptr when nobody requests.
  function automatic int rr_next(input int n, input int ptr, input logic [MAX_REQ-1:0] req);
    int c;
    int res;
    logic hit;
    logic [MAX_REQ-1:0] sh;
    c   = ptr;
    res = ptr;
    hit = 1'b0;
    sh  = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n && !hit) begin
        c  = (c >= n - 1) ? 0 : c + 1;
        sh = req >> c;
        if (sh[0]) begin
          res = c;
          hit = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// rtl/stream_rr_arbiter_pick.sv - rr_priority_pick: combinational rotate and priority encode
module rr_priority_pick
  import stream_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext = MAX_REQ'(req);
    found   = |req;
    idx     = IW'(rr_next(N, int'(ptr), req_ext));
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin merge of NUM_REQ streams into one sink
// Define STREAM_RR_ARBITER_PKT_LOCK_EN to hold the grant for a whole packet.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        inValid,
  input  logic [NUM_REQ-1:0]        inLast,
  input  logic [NUM_REQ*DATA_W-1:0] dIn,
  output logic [NUM_REQ-1:0]        inReady,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [DATA_W-1:0]         dOut,
  output logic                      outLast,
  output logic [ID_W-1:0]           outId
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("stream_rr_arbiter: NUM_REQ must be at least 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("stream_rr_arbiter: DATA_W must be at least 1");
  end

  logic            rst_q;
  arb_state_e      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] g;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic            accept;

  rr_priority_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req  (inValid),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Forwarding is purely combinational; only the grant bookkeeping is registered.
  always_comb begin
    g        = (state == ST_LOCK) ? gnt : pick_idx;
    outValid = rst_q && (state == ST_LOCK || pick_found) && inValid[g];
    dOut     = dIn[int'(g)*DATA_W +: DATA_W];
    outLast  = inLast[g];
    outId    = g;
    inReady  = '0;
    inReady[g] = outValid && outReady;
    accept   = outValid && outReady;
  end

  always_ff @(posedge clk) begin
    rst_q <= rstn;
    if (!rst_q) begin
      state <= ST_IDLE;
      ptr   <= ID_W'(NUM_REQ - 1);
      gnt   <= '0;
    end else if (accept) begin
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
      if (outLast) begin
        state <= ST_IDLE;
        ptr   <= g;
      end else begin
        state <= ST_LOCK;
        gnt   <= g;
      end
`else
      ptr <= g;
`endif
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb/tb_stream_rr_arbiter.sv - self-checking bench for stream_rr_arbiter (4- and 3-requester instances)
module tb_stream_rr_arbiter;

`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [3:0]  v0, l0, r0;
  logic [31:0] d0;
  logic        ov0, ordy0, ol0;
  logic [7:0]  do0;
  logic [1:0]  id0;

  logic [2:0]  v1, l1, r1;
  logic [23:0] d1;
  logic        ov1, ordy1, ol1;
  logic [7:0]  do1;
  logic [1:0]  id1;

  stream_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .rstn(rstn), .inValid(v0), .inLast(l0), .dIn(d0), .inReady(r0),
    .outValid(ov0), .outReady(ordy0), .dOut(do0), .outLast(ol0), .outId(id0)
  );

  stream_rr_arbiter #(.NUM_REQ(3), .DATA_W(8)) dut3 (
    .clk(clk), .rstn(rstn), .inValid(v1), .inLast(l1), .dIn(d1), .inReady(r1),
    .outValid(ov1), .outReady(ordy1), .dOut(do1), .outLast(ol1), .outId(id1)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Upstream packet sources, one beat list per requester per instance.
  logic [7:0] sd [2][4][16];
  bit         sl [2][4][16];
  int         slen [2][4];
  int         spos [2][4];
  bit         sgate [2][4];
  logic [3:0] fire [2];

  // Reference model state.
  int mptr [2], nptr [2], mgnt [2], ngnt [2];
  bit mlock [2], nlock [2], mrq [2], nrq [2];

  int dlog_id [2][32], dlog_d [2][32], dlen [2];
  int mlog_id [2][32], mlog_d [2][32], mlen [2];

  function automatic bit bit_of(input logic [31:0] x, input int i);
    logic [31:0] s;
    s = x >> i;
    return s[0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    logic [3:0]  vv [2];
    logic [3:0]  ll [2];
    logic [31:0] dd [2];
    for (int u = 0; u < 2; u++) begin
      vv[u] = '0; ll[u] = '0; dd[u] = '0;
      for (int i = 0; i < 4; i++) begin
        if (spos[u][i] < slen[u][i] && !sgate[u][i]) begin
          vv[u][i] = 1'b1;
          ll[u][i] = sl[u][i][spos[u][i]];
          dd[u][i*8 +: 8] = sd[u][i][spos[u][i]];
        end
      end
    end
    v0 = vv[0]; l0 = ll[0]; d0 = dd[0];
    v1 = vv[1][2:0]; l1 = ll[1][2:0]; d1 = dd[1][23:0];
  endtask

  task automatic load(input int u, input int i, input logic [7:0] d, input bit last);
    sd[u][i][slen[u][i]] = d;
    sl[u][i][slen[u][i]] = last;
    slen[u][i]++;
    drive();
  endtask

  task automatic clear_src();
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) begin
        slen[u][i] = 0; spos[u][i] = 0; sgate[u][i] = 1'b0;
      end
    drive();
  endtask

  task automatic clear_logs();
    for (int u = 0; u < 2; u++) begin
      dlen[u] = 0; mlen[u] = 0;
    end
  endtask

  // Spec-level grant: locked holder, else first valid requester after ptr, circularly.
  task automatic m_eval(input int n, input bit rq, input int ptr, input bit lock, input int gnt,
                        input logic [3:0] v, output bit ov, output int g);
    bit hit;
    ov = 1'b0; g = 0; hit = 1'b0;
    if (rq) begin
      if (lock) begin
        g = gnt;
        ov = bit_of(32'(v), gnt);
      end else begin
        for (int k = 1; k <= n; k++) begin
          if (!hit && bit_of(32'(v), (ptr + k) % n)) begin
            g = (ptr + k) % n; ov = 1'b1; hit = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int u, input int n, input logic [3:0] v, input logic [3:0] l,
                          input logic [31:0] d, input bit ordy, input logic [3:0] rdy, input bit ov,
                          input logic [7:0] dout, input bit olast, input int oid);
    bit eov;
    int g;
    logic [3:0] erdy;
    logic [31:0] sh;
    m_eval(n, mrq[u], mptr[u], mlock[u], mgnt[u], v, eov, g);
    erdy = (eov && ordy) ? 4'(1 << g) : 4'b0;
    sh = d >> (g * 8);
    if (chk_en) begin
      chk($sformatf("u%0d_out_valid", u), 32'(ov), 32'(eov));
      chk($sformatf("u%0d_in_ready", u), 32'(rdy), 32'(erdy));
      if (eov) begin
        chk($sformatf("u%0d_out_id", u), 32'(oid), 32'(g));
        chk($sformatf("u%0d_d_out", u), 32'(dout), 32'(sh[7:0]));
        chk($sformatf("u%0d_out_last", u), 32'(olast), 32'(bit_of(32'(l), g)));
      end
      if (ov) chk($sformatf("u%0d_id_range", u), 32'(oid < n), 32'd1);
    end
    nptr[u] = mptr[u]; nlock[u] = mlock[u]; ngnt[u] = mgnt[u];
    if (!mrq[u]) begin
      nptr[u] = n - 1; nlock[u] = 1'b0;
    end else if (eov && ordy) begin
      if (LOCK_EN && !bit_of(32'(l), g)) begin
        nlock[u] = 1'b1; ngnt[u] = g;
      end else begin
        nlock[u] = 1'b0; nptr[u] = g;
      end
      if (mlen[u] < 32) begin
        mlog_id[u][mlen[u]] = g; mlog_d[u][mlen[u]] = int'(sh[7:0]); mlen[u]++;
      end
    end
    nrq[u] = rstn;
    if (ov && ordy && dlen[u] < 32) begin
      dlog_id[u][dlen[u]] = oid; dlog_d[u][dlen[u]] = int'(dout); dlen[u]++;
    end
    fire[u] = v & rdy;
  endtask

  task automatic step();
    @(negedge clk);
    cmp_inst(0, 4, v0, l0, d0, ordy0, r0, ov0, do0, ol0, int'(id0));
    cmp_inst(1, 3, {1'b0, v1}, {1'b0, l1}, {8'h0, d1}, ordy1, {1'b0, r1}, ov1, do1, ol1, int'(id1));
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      mptr[u] = nptr[u]; mlock[u] = nlock[u]; mgnt[u] = ngnt[u]; mrq[u] = nrq[u];
      for (int i = 0; i < 4; i++)
        if (fire[u][i]) spos[u][i]++;
    end
    drive();
  endtask

  task automatic chk_log(input string name, input int u, input int len, input int eid[8], input int ed[8]);
    chk({name, "_dut_len"}, 32'(dlen[u]), 32'(len));
    chk({name, "_model_len"}, 32'(mlen[u]), 32'(len));
    for (int k = 0; k < len && k < 8; k++) begin
      chk($sformatf("%s_dut_id%0d", name, k), 32'(dlog_id[u][k]), 32'(eid[k]));
      chk($sformatf("%s_dut_data%0d", name, k), 32'(dlog_d[u][k]), 32'(ed[k]));
      chk($sformatf("%s_model_id%0d", name, k), 32'(mlog_id[u][k]), 32'(eid[k]));
    end
  endtask

  initial begin
    rstn = 1'b0; ordy0 = 1'b0; ordy1 = 1'b0;
    for (int u = 0; u < 2; u++) begin
      mptr[u] = 0; mgnt[u] = 0; mlock[u] = 1'b0; mrq[u] = 1'b0; fire[u] = '0;
    end
    clear_src();
    clear_logs();

    // Reset with all requesters valid: outputs must stay quiet.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) load(0, i, 8'(i * 16 + k), 1'b1);
    ordy0 = 1'b1;
    step(); step();
    chk_en = 1'b1;
    step();
    #1;
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_in_ready", 32'(r0), 32'd0);

    // Single-beat round robin from ptr=NUM_REQ-1.
    clear_logs();
    rstn = 1'b1;
    step();
    clear_logs();
    repeat (5) step();
    chk_log("rr4", 0, 5, '{0, 1, 2, 3, 0, 0, 0, 0}, '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 0, 0, 0});
    ordy0 = 1'b0;
    clear_src();

    // Three-beat packet from requester 2 with 0 and 3 competing.
    clear_logs();
    load(0, 2, 8'hA0, 1'b0); load(0, 2, 8'hA1, 1'b0); load(0, 2, 8'hA2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      load(0, 0, 8'(k), 1'b1);
      load(0, 3, 8'(8'h30 + k), 1'b1);
    end
    ordy0 = 1'b1;
    repeat (5) step();
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    chk_log("pkt", 0, 5, '{2, 2, 2, 3, 0, 0, 0, 0}, '{8'hA0, 8'hA1, 8'hA2, 8'h30, 8'h00, 0, 0, 0});
`else
    chk_log("pkt", 0, 5, '{2, 3, 0, 2, 3, 0, 0, 0}, '{8'hA0, 8'h30, 8'h00, 8'hA1, 8'h31, 0, 0, 0});
`endif
    ordy0 = 1'b0;
    clear_src();

    // Lock with stall and upstream bubble.
    clear_logs();
    load(0, 1, 8'hB0, 1'b0); load(0, 1, 8'hB1, 1'b0); load(0, 1, 8'hB2, 1'b1);
    ordy0 = 1'b1;
    step();
    load(0, 0, 8'h01, 1'b1); load(0, 0, 8'h02, 1'b1);
    ordy0 = 1'b0;
    repeat (5) step();
    sgate[0][1] = 1'b1; drive();
    ordy0 = 1'b1;
    step();
    #1;
    chk("stall_out_valid", 32'(ov0), LOCK_EN ? 32'd0 : 32'd1);
    chk("stall_out_id", 32'(id0), LOCK_EN ? 32'd1 : 32'd0);
    step();
    sgate[0][1] = 1'b0; drive();
    repeat (3) step();
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    chk_log("stall", 0, 4, '{1, 1, 1, 0, 0, 0, 0, 0}, '{8'hB0, 8'hB1, 8'hB2, 8'h01, 0, 0, 0, 0});
`else
    chk_log("stall", 0, 5, '{1, 0, 0, 1, 1, 0, 0, 0}, '{8'hB0, 8'h01, 8'h02, 8'hB1, 8'hB2, 0, 0, 0});
`endif
    ordy0 = 1'b0;
    clear_src();

    // Backpressure: data held until accepted.
    clear_logs();
    load(0, 3, 8'hA5, 1'b1); load(0, 3, 8'h3C, 1'b1);
    #1; chk("bp_hold0", 32'(do0), 32'hA5); chk("bp_valid0", 32'(ov0), 32'd1);
    step();
    ordy0 = 1'b1;
    #1; chk("bp_hold1", 32'(do0), 32'hA5);
    step();
    ordy0 = 1'b0;
    #1; chk("bp_hold2", 32'(do0), 32'h3C);
    step();
    ordy0 = 1'b1;
    #1; chk("bp_hold3", 32'(do0), 32'h3C);
    step();
    ordy0 = 1'b0;
    chk_log("bp", 0, 2, '{3, 3, 0, 0, 0, 0, 0, 0}, '{8'hA5, 8'h3C, 0, 0, 0, 0, 0, 0});
    load(0, 2, 8'h22, 1'b1); load(0, 3, 8'h33, 1'b1);
    #1; chk("bp_ptr3_pick", 32'(id0), 32'd2);
    clear_src();

    // Reset in the middle of a 4-beat packet from requester 1.
    load(0, 1, 8'hC0, 1'b0); load(0, 1, 8'hC1, 1'b0); load(0, 1, 8'hC2, 1'b0); load(0, 1, 8'hC3, 1'b1);
    ordy0 = 1'b1;
    step(); step();
    ordy0 = 1'b0;
    load(0, 0, 8'h07, 1'b1);
    rstn = 1'b0;
    step();
    #1; chk("midrst_out_valid", 32'(ov0), 32'd0); chk("midrst_in_ready", 32'(r0), 32'd0);
    rstn = 1'b1;
    step();
    #1; chk("postrst_valid", 32'(ov0), 32'd1); chk("postrst_id", 32'(id0), 32'd0);
    chk("postrst_data", 32'(do0), 32'h07);
    clear_src();

    // Three-requester instance.
    clear_logs();
    ordy1 = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 2; k++) load(1, i, 8'(8'h40 + i * 16 + k), 1'b1);
    repeat (6) step();
    chk_log("rr3", 1, 6, '{0, 1, 2, 0, 1, 2, 0, 0}, '{8'h40, 8'h50, 8'h60, 8'h41, 8'h51, 8'h61, 0, 0});
    clear_logs();
    load(1, 0, 8'h80, 1'b0); load(1, 0, 8'h81, 1'b1);
    load(1, 1, 8'h90, 1'b0); load(1, 1, 8'h91, 1'b1);
    repeat (4) step();
`ifdef STREAM_RR_ARBITER_PKT_LOCK_EN
    chk_log("mb3", 1, 4, '{0, 0, 1, 1, 0, 0, 0, 0}, '{8'h80, 8'h81, 8'h90, 8'h91, 0, 0, 0, 0});
`else
    chk_log("mb3", 1, 4, '{0, 1, 0, 1, 0, 0, 0, 0}, '{8'h80, 8'h90, 8'h81, 8'h91, 0, 0, 0, 0});
`endif
    ordy1 = 1'b0;
    clear_src();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
